// File: rtl/mac_load_controller.sv
// Load/run sequencer for the synapse MAC: byte-serial fill of the weight and spike vectors, one-shot sampling of the MAC sum.
// Optional MAC_ACCUMULATE_EN: COMPUTE accumulates with signed saturation and CLEAR zeroes the result.
module mac_load_controller #(
  parameter int N_STAGE = 6,
  parameter int BUS_W   = 8,
  parameter int ACC_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           cmd,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [BUS_W-1:0]     data_in,
  input  logic                 data_valid,
  output logic                 data_ready,
  output logic [2**N_STAGE-1:0] w_out,
  output logic [2**N_STAGE-1:0] x_out,
  input  logic [N_STAGE+1:0]   mac_sum,
  output logic [ACC_W-1:0]     result,
  output logic                 result_valid,
  output logic                 busy
);
  localparam int N     = 2**N_STAGE;
  localparam int BEATS = N / BUS_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [1:0] CMD_CLEAR  = 2'b00;
  localparam logic [1:0] CMD_LOAD_W = 2'b01;
  localparam logic [1:0] CMD_LOAD_X = 2'b10;
  localparam logic [1:0] CMD_RUN    = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_LOAD_W, S_LOAD_X, S_COMPUTE} state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [N-1:0]              w_q, x_q;
  logic [BEATS-1:0]          wr_w, wr_x;
  logic signed [ACC_W-1:0]   result_q, result_d;
  logic                      rvld_q;
  logic signed [ACC_W-1:0]   ms_ext;

  assign ms_ext = ACC_W'($signed(mac_sum));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_ready  = 1'b0;
    data_ready = 1'b0;
    wr_w       = '0;
    wr_x       = '0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          case (cmd)
            CMD_LOAD_W: begin state_d = S_LOAD_W; cnt_d = '0; end
            CMD_LOAD_X: begin state_d = S_LOAD_X; cnt_d = '0; end
            CMD_RUN:    state_d = S_COMPUTE;
            CMD_CLEAR:  state_d = S_IDLE;
            default:    state_d = S_IDLE;
          endcase
        end
      end
      S_LOAD_W, S_LOAD_X: begin
        data_ready = 1'b1;
        if (data_valid) begin
          if (state_q == S_LOAD_W) wr_w[cnt_q] = 1'b1;
          else                     wr_x[cnt_q] = 1'b1;
          if (cnt_q == CNT_W'(BEATS-1)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_COMPUTE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

`ifdef MAC_ACCUMULATE_EN
  // One extra bit catches signed overflow; clamp instead of wrapping.
  logic signed [ACC_W:0] acc_sum;
  assign acc_sum = {result_q[ACC_W-1], result_q} + {ms_ext[ACC_W-1], ms_ext};

  always_comb begin
    result_d = result_q;
    if (state_q == S_COMPUTE) begin
      if (acc_sum[ACC_W] != acc_sum[ACC_W-1])
        result_d = acc_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      else
        result_d = acc_sum[ACC_W-1:0];
    end else if (state_q == S_IDLE && cmd_valid && cmd == CMD_CLEAR) begin
      result_d = '0;
    end
  end
`else
  always_comb begin
    result_d = result_q;
    if (state_q == S_COMPUTE) result_d = ms_ext;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      w_q      <= '0;
      x_q      <= '0;
      result_q <= '0;
      rvld_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      rvld_q   <= (state_q == S_COMPUTE);
      for (int k = 0; k < BEATS; k++) begin
        if (wr_w[k]) w_q[k*BUS_W +: BUS_W] <= data_in;
        if (wr_x[k]) x_q[k*BUS_W +: BUS_W] <= data_in;
      end
    end
  end

  assign w_out        = w_q;
  assign x_out        = x_q;
  assign result       = result_q;
  assign result_valid = rvld_q;
  assign busy         = (state_q != S_IDLE);
endmodule

// File: tb/tb_mac_load_controller.sv
// Randomized self-checking bench for mac_load_controller against a byte-level vector/result model.
module tb_mac_load_controller;
  localparam int N_STAGE = 6;
  localparam int BUS_W   = 8;
`ifdef MAC_ACCUMULATE_EN
  localparam int ACC_W   = 8;
`else
  localparam int ACC_W   = 16;
`endif
  localparam int N     = 2**N_STAGE;
  localparam int BEATS = N / BUS_W;
  localparam int MS_W  = N_STAGE + 2;

  localparam logic [1:0] C_CLEAR = 2'b00, C_LW = 2'b01, C_LX = 2'b10, C_RUN = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n = 1'b0;
  logic [1:0]        cmd = '0;
  logic              cmd_valid = 1'b0, cmd_ready;
  logic [BUS_W-1:0]  data_in = '0;
  logic              data_valid = 1'b0, data_ready;
  logic [N-1:0]      w_out, x_out;
  logic [MS_W-1:0]   mac_sum = '0;
  logic [ACC_W-1:0]  result;
  logic              result_valid, busy;

  mac_load_controller #(.N_STAGE(N_STAGE), .BUS_W(BUS_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
    .w_out(w_out), .x_out(x_out), .mac_sum(mac_sum),
    .result(result), .result_valid(result_valid), .busy(busy)
  );

  int checks = 0, errors = 0;
  logic [N-1:0]     w_m = '0, x_m = '0;
  logic [ACC_W-1:0] r_m = '0;

  function automatic logic [ACC_W-1:0] next_res(input logic [ACC_W-1:0] cur, input logic [MS_W-1:0] ms);
    int s, c, t;
    s = $signed(ms);
    c = $signed(cur);
`ifdef MAC_ACCUMULATE_EN
    t = c + s;
    if (t > (2**(ACC_W-1)) - 1) t = (2**(ACC_W-1)) - 1;
    if (t < -(2**(ACC_W-1)))    t = -(2**(ACC_W-1));
`else
    t = s + (c - c);
`endif
    return ACC_W'(t);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] c);
    int n = 0;
    cmd = c;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 64) begin step(); n++; end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_accept_timeout cmd=%0d cmd_ready=%b expected 1", c, cmd_ready);
    end
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic load_vec(input bit is_w, input logic [N-1:0] v, input int stall_at,
                          input bit rand_stall, input bit hold_run);
    send_cmd(is_w ? C_LW : C_LX);
    if (hold_run) begin cmd = C_RUN; cmd_valid = 1'b1; end
    for (int k = 0; k < BEATS; k++) begin
      if (k == stall_at || (rand_stall && $urandom_range(0, 2) == 0)) begin
        data_valid = 1'b0;
        data_in = BUS_W'($urandom);
        step();
      end
      data_in = v[k*BUS_W +: BUS_W];
      data_valid = 1'b1;
      checks++;
      if ({data_ready, busy, cmd_ready} !== 3'b110) begin
        errors++;
        $display("FAIL load_handshake beat=%0d got dr/busy/cr=%b expected 110", k, {data_ready, busy, cmd_ready});
      end
      step();
      if (is_w) w_m[k*BUS_W +: BUS_W] = data_in;
      else      x_m[k*BUS_W +: BUS_W] = data_in;
      checks++;
      if (w_out !== w_m || x_out !== x_m) begin
        errors++;
        $display("FAIL load_partial beat=%0d w=%h x=%h expected w=%h x=%h", k, w_out, x_out, w_m, x_m);
      end
    end
    data_valid = 1'b0;
    checks++;
    if ({busy, data_ready, cmd_ready} !== 3'b001) begin
      errors++;
      $display("FAIL load_done busy/dr/cr=%b expected 001", {busy, data_ready, cmd_ready});
    end
  endtask

  task automatic run(input logic [MS_W-1:0] ms, input bit hold_cmd);
    mac_sum = ms;
    send_cmd(C_RUN);
    checks++;
    if ({busy, result_valid, cmd_ready, data_ready} !== 4'b1000) begin
      errors++;
      $display("FAIL run_compute busy/rv/cr/dr=%b expected 1000", {busy, result_valid, cmd_ready, data_ready});
    end
    if (hold_cmd) begin cmd = C_LW; cmd_valid = 1'b1; end
    step();
    cmd_valid = 1'b0;
    r_m = next_res(r_m, ms);
    checks++;
    if (result_valid !== 1'b1 || result !== r_m || busy !== 1'b0) begin
      errors++;
      $display("FAIL run_result rv=%b result=%h busy=%b expected rv=1 result=%h busy=0", result_valid, result, busy, r_m);
    end
    step();
    checks++;
    if (result_valid !== 1'b0 || busy !== 1'b0 || result !== r_m) begin
      errors++;
      $display("FAIL run_after rv=%b busy=%b result=%h expected rv=0 busy=0 result=%h", result_valid, busy, result, r_m);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if (w_out !== '0 || x_out !== '0 || result !== '0 || result_valid !== 1'b0 ||
        busy !== 1'b0 || cmd_ready !== 1'b1 || data_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state w=%h x=%h res=%h rv=%b busy=%b cr=%b dr=%b expected zeros with cr=1",
               w_out, x_out, result, result_valid, busy, cmd_ready, data_ready);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_load_w();
    logic [N-1:0] v;
    for (int k = 0; k < BEATS; k++) v[k*BUS_W +: BUS_W] = BUS_W'(k + 1);
    load_vec(1'b1, v, 3, 1'b0, 1'b0);
    checks++;
    if (w_out !== 64'h0807060504030201 || x_out !== '0) begin
      errors++;
      $display("FAIL load_w_value w=%h x=%h expected w=0807060504030201 x=0", w_out, x_out);
    end
  endtask

  task automatic test_run();
    load_vec(1'b0, {N{1'b1}}, -1, 1'b0, 1'b0);
    run(MS_W'(-10), 1'b1);
`ifndef MAC_ACCUMULATE_EN
    checks++;
    if (result !== 16'hFFF6) begin
      errors++;
      $display("FAIL run_neg10 result=%h expected fff6", result);
    end
`endif
  endtask

  task automatic test_reset_mid();
    load_vec(1'b0, {$urandom, $urandom}, -1, 1'b0, 1'b0);
    send_cmd(C_LW);
    for (int k = 0; k < 4; k++) begin
      data_in = BUS_W'($urandom | 1);
      data_valid = 1'b1;
      step();
    end
    data_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    w_m = '0; x_m = '0; r_m = '0;
    checks++;
    if (w_out !== '0 || x_out !== '0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_midload w=%h x=%h busy=%b cr=%b expected 0 0 0 1", w_out, x_out, busy, cmd_ready);
    end
    load_vec(1'b1, {$urandom, $urandom}, -1, 1'b0, 1'b0);
    mac_sum = MS_W'(37);
    send_cmd(C_RUN);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    w_m = '0;
    checks++;
    if (result_valid !== 1'b0 || result !== '0 || busy !== 1'b0 || w_out !== '0) begin
      errors++;
      $display("FAIL reset_compute rv=%b result=%h busy=%b w=%h expected 0 0 0 0", result_valid, result, busy, w_out);
    end
    step();
    checks++;
    if (result_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_compute_pulse rv=%b expected 0", result_valid);
    end
  endtask

  task automatic test_ignore();
    for (int i = 0; i < 3; i++) begin
      data_in = BUS_W'($urandom);
      data_valid = 1'b1;
      step();
    end
    data_valid = 1'b0;
    checks++;
    if (w_out !== w_m || x_out !== x_m || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_data w=%h x=%h busy=%b expected w=%h x=%h busy=0", w_out, x_out, busy, w_m, x_m);
    end
    mac_sum = MS_W'(21);
    load_vec(1'b0, {$urandom, $urandom}, 2, 1'b1, 1'b1);
    step();
    cmd_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || data_ready !== 1'b0) begin
      errors++;
      $display("FAIL held_run busy=%b dr=%b expected busy=1 dr=0", busy, data_ready);
    end
    step();
    r_m = next_res(r_m, MS_W'(21));
    checks++;
    if (result_valid !== 1'b1 || result !== r_m) begin
      errors++;
      $display("FAIL held_run_result rv=%b result=%h expected rv=1 result=%h", result_valid, result, r_m);
    end
    step();
  endtask

  task automatic test_clear();
    send_cmd(C_CLEAR);
`ifdef MAC_ACCUMULATE_EN
    r_m = '0;
`endif
    checks++;
    if (result !== r_m || result_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL clear result=%h rv=%b busy=%b cr=%b expected result=%h rv=0 busy=0 cr=1",
               result, result_valid, busy, cmd_ready, r_m);
    end
  endtask

  task automatic test_repeat_run();
    logic [ACC_W-1:0] first;
    run(MS_W'($urandom), 1'b0);
    first = result;
    run(mac_sum, 1'b0);
`ifndef MAC_ACCUMULATE_EN
    checks++;
    if (result !== first) begin
      errors++;
      $display("FAIL repeat_run result=%h expected %h", result, first);
    end
`endif
  endtask

`ifdef MAC_ACCUMULATE_EN
  task automatic test_accumulate();
    logic [ACC_W-1:0] exp_seq [5] = '{8'd127, 8'd127, 8'd127, 8'h9C, 8'h80};
    test_clear();
    for (int i = 0; i < 5; i++) begin
      if (i == 3) test_clear();
      run(i < 3 ? MS_W'(127) : MS_W'(-100), 1'b0);
      checks++;
      if (result !== exp_seq[i]) begin
        errors++;
        $display("FAIL accumulate step=%0d result=%h expected %h", i, result, exp_seq[i]);
      end
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0: load_vec(1'b1, {$urandom, $urandom}, -1, 1'b1, 1'b0);
        1: load_vec(1'b0, {$urandom, $urandom}, -1, 1'b1, 1'b0);
        2: run(MS_W'($urandom), $urandom_range(0, 1) == 1);
        default: test_clear();
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_load_w();
    test_run();
    test_reset_mid();
    test_ignore();
    test_clear();
    test_repeat_run();
`ifdef MAC_ACCUMULATE_EN
    test_accumulate();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
